uart_flow_link: RTL and testbench
=================================

Name: uart_flow_link

Overview:
Parametrised full-duplex UART link with hardware RTS/CTS flow control, for the BNN controller's host interface. Converts the serial pins to valid/ready byte streams. The RX path feeds a first-word-fall-through FIFO, and CTS throttles the host before that FIFO overflows. Frame width, parity mode, bit timing and buffer depth are configurable, which the current fixed 8N1 link does not support.

Parameters:
CLKS_PER_BIT, 87, clk cycles per UART bit (10 MHz / 115200); must be >= 4.
DATA_BITS, 8, payload bits per frame (5..9).
PARITY, 0, 0 = none, 1 = even, 2 = odd.
FIFO_DEPTH, 8, RX FIFO entries; must be a power of 2 and >= 4.
CTS_MARGIN, 2, free entries remaining at which CTS deasserts.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  synchronous, active-high reset.
UART_Rx  in  1  serial receive line; idle high.
UART_RTS  in  1  peer ready to accept our TX (1 = may send).
UART_Tx  out  1  serial transmit line; idle high.
UART_CTS  out  1  we can accept RX data (1 = host may send).
rx_data  out  DATA_BITS  head of RX FIFO.
rx_valid  out  1  RX FIFO not empty.
rx_ready  in  1  consumer pops the head when rx_valid & rx_ready.
tx_data  in  DATA_BITS  byte to transmit.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  TX accepts on tx_valid & tx_ready.
rx_frame_err  out  1  1-cycle pulse: stop bit sampled low.
rx_parity_err  out  1  1-cycle pulse: parity mismatch.
rx_overrun  out  1  1-cycle pulse: byte dropped because FIFO was full.

Behaviour:
- Reset: single clk, synchronous, active-high (rst). On a rst cycle: UART_Tx=1, UART_CTS=0, rx_valid=0, tx_ready=0, all error pulses 0, FIFO emptied, both FSMs to IDLE, RX synchronizer preset to 1. rst asserted mid-frame abandons the frame; there is no partial output.
- UART_Rx and UART_RTS each pass through a 2-FF synchronizer. Sync latency is 2 cycles.
- Frame format: start bit 0, DATA_BITS bits LSB first, optional parity bit, one stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: a synced 1->0 edge moves to START and loads the counter with CLKS_PER_BIT/2 (integer division).
  - START: at counter expiry, if the line is 0, go to DATA; if 1, it was a glitch, so return to IDLE with nothing reported.
  - DATA: sample every CLKS_PER_BIT cycles at bit centre; shift right into the data register.
  - PARITY (only if PARITY != 0): sample and compare with the XOR of the data (even parity) or its inverse (odd parity).
  - STOP: sample the stop bit.
    - Stop=1 and parity OK: push the byte. If the FIFO is full, drop the byte and pulse rx_overrun. A pop in the same cycle does not rescue it; a full FIFO means the push is dropped.
    - Stop=0: pulse rx_frame_err, discard the byte, go to WAIT_HIGH. WAIT_HIGH returns to IDLE on the first synced 1.
    - Parity bad (stop OK): pulse rx_parity_err, discard the byte, go to IDLE.
    - Both bad: both pulses fire in the same cycle.
  - Error and overrun pulses occur in the cycle the STOP sample is taken.
- RX FIFO is first-word fall-through.
  - rx_valid=1 and rx_data is valid the cycle after the push edge.
  - Pop and push in the same cycle with the FIFO not full: both happen and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. The count register is log2(FIFO_DEPTH)+1 bits wide.
- UART_CTS is registered: UART_CTS = (FIFO_DEPTH - count) > CTS_MARGIN, so CTS=1 the first cycle after rst is released. A frame already in flight when CTS drops is still received.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - tx_ready = (state==IDLE) & synced RTS & ~rst (combinational).
  - On accept, the byte and parity are latched. UART_Tx goes 0 on the next edge.
  - The frame lasts (2 + DATA_BITS + (PARITY!=0)) * CLKS_PER_BIT cycles. Return to IDLE is at the end of the stop bit.
  - Earliest back-to-back accept is the same cycle the FSM re-enters IDLE, so there is no extra idle bit.
  - RTS dropping mid-frame does not abort the frame; only the next accept is blocked.
- UART_Tx is driven from a flop (glitch-free).

Test Plan:
- CLKS_PER_BIT=8, 8N1: drive RX frame 0xA5 -> rx_valid rises 1 cycle after the stop-bit sample, rx_data=0xA5, no error pulses; pop with rx_ready -> rx_valid=0.
- TX 0x3C with RTS=1 -> UART_Tx sequence 0, 0,0,1,1,1,1,0,0, 1 at 8 cycles/bit; tx_ready low for exactly 80 cycles. Hold RTS=0 -> tx_valid held, line stays 1, tx_ready=0.
- FIFO_DEPTH=4, CTS_MARGIN=1, no pops: send 4 frames -> CTS=0 after the 3rd push. The 4th frame is stored; a 5th frame pulses rx_overrun and the FIFO still holds bytes 1-4 in order.
- PARITY=1, send 0x07 with parity bit 0 -> rx_parity_err pulse, nothing pushed. Then send a frame with stop=0 -> rx_frame_err pulse; the next valid frame is received after the line returns high.
- A 2-cycle low glitch on UART_Rx -> no state change, no pulses, no push.
- Assert rst mid-TX (bit 3) and mid-RX -> next cycle UART_Tx=1, CTS=0, rx_valid=0. After release, CTS=1 and a fresh 0x55 frame is received correctly.

Source files
------------

// File: rtl/uart_flow_link.sv
// Full-duplex UART with RTS/CTS flow control that turns the serial pins into
// valid/ready byte streams. Received bytes go into a first-word-fall-through
// FIFO, and CTS throttles the host before that FIFO overflows.
// Ports:
//   clk, rst            : system clock; synchronous active-high reset
//   UART_Rx, UART_RTS   : serial receive line and peer-ready input (asynchronous)
//   UART_Tx, UART_CTS   : serial transmit line and we-can-accept output
//   rx_data/valid/ready : RX byte stream; the FIFO head is shown on rx_data
//   tx_data/valid/ready : TX byte stream
//   rx_frame_err, rx_parity_err, rx_overrun : single-cycle error pulses
`timescale 1ns/1ps
module uart_flow_link #(
   parameter int unsigned CLKS_PER_BIT = 87,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned CTS_MARGIN   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 UART_Rx,
   input  logic                 UART_RTS,
   output logic                 UART_Tx,
   output logic                 UART_CTS,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CW    = AW + 1;
   localparam bit HAS_PAR = (PARITY != 0);
   localparam bit ODD_PAR = (PARITY == 2);
   localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_BIT   = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_BITS - 1);

   // Two-flop synchronizers. RX is preset high so reset never looks like a start edge.
   logic rx_meta, rx_s, rx_prev, rts_meta, rts_s;
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta  <= 1'b1;
         rx_s     <= 1'b1;
         rx_prev  <= 1'b1;
         rts_meta <= 1'b0;
         rts_s    <= 1'b0;
      end else begin
         rx_meta  <= UART_Rx;
         rx_s     <= rx_meta;
         rx_prev  <= rx_s;
         rts_meta <= UART_RTS;
         rts_s    <= rts_meta;
      end
   end

   // ------------------------------------------------------------------ RX
   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
   } rx_state_t;

   rx_state_t               rx_state, rx_state_nx;
   logic [CNT_W-1:0]        rx_cnt;
   logic [IDX_W-1:0]        rx_idx;
   logic [DATA_BITS-1:0]    rx_shift;
   logic                    rx_par_bit;
   logic                    rx_tick_c, par_ok_c;
   logic                    push_req_c, frame_err_c, parity_err_c;

   assign rx_tick_c = (rx_cnt == '0);
   assign par_ok_c  = HAS_PAR ? (rx_par_bit == ((^rx_shift) ^ ODD_PAR)) : 1'b1;

   // RX state register
   always_ff @(posedge clk) begin
      if (rst) rx_state <= RX_IDLE;
      else     rx_state <= rx_state_nx;
   end

   // RX next-state logic
   always_comb begin
      rx_state_nx = rx_state;
      case (rx_state)
         RX_IDLE:      if (rx_prev && !rx_s) rx_state_nx = RX_START;
         RX_START:     if (rx_tick_c) rx_state_nx = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:      if (rx_tick_c && rx_idx == LAST_IDX)
                          rx_state_nx = HAS_PAR ? RX_PARITY : RX_STOP;
         RX_PARITY:    if (rx_tick_c) rx_state_nx = RX_STOP;
         RX_STOP:      if (rx_tick_c) rx_state_nx = rx_s ? RX_IDLE : RX_WAIT_HIGH;
         RX_WAIT_HIGH: if (rx_s) rx_state_nx = RX_IDLE;
         default:      rx_state_nx = RX_IDLE;
      endcase
   end

   // RX outputs: the push request and error flags are all decided at the stop-bit sample
   always_comb begin
      push_req_c   = 1'b0;
      frame_err_c  = 1'b0;
      parity_err_c = 1'b0;
      if (rx_state == RX_STOP && rx_tick_c) begin
         frame_err_c  = ~rx_s;
         parity_err_c = ~par_ok_c;
         push_req_c   = rx_s & par_ok_c;
      end
   end

   // RX bit timing and data capture; the counter reloads with half a bit while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_cnt     <= '0;
         rx_idx     <= '0;
         rx_shift   <= '0;
         rx_par_bit <= 1'b0;
      end else begin
         if (rx_state == RX_IDLE) begin
            rx_cnt <= HALF_BIT;
            rx_idx <= '0;
         end else if (rx_tick_c) begin
            rx_cnt <= BIT_RELOAD;
         end else begin
            rx_cnt <= rx_cnt - CNT_W'(1);
         end
         if (rx_state == RX_DATA && rx_tick_c) begin
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            rx_idx   <= rx_idx + IDX_W'(1);
         end
         if (rx_state == RX_PARITY && rx_tick_c) rx_par_bit <= rx_s;
      end
   end

   // ---------------------------------------------------------------- FIFO
   logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count, count_nx;
   logic                 full_c, wr_c, pop_c;

   assign full_c   = (count == CW'(FIFO_DEPTH));
   assign wr_c     = push_req_c & ~full_c;
   assign pop_c    = rx_valid & rx_ready;
   assign count_nx = count + CW'(wr_c) - CW'(pop_c);
   assign rx_data  = fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst && wr_c) fifo_mem[wr_ptr] <= rx_shift;
   end

   // FIFO pointers and status; a push that meets a full FIFO is dropped even if a pop occurs in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         rx_valid      <= 1'b0;
         UART_CTS      <= 1'b0;
         rx_overrun    <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
      end else begin
         if (wr_c)  wr_ptr <= wr_ptr + AW'(1);
         if (pop_c) rd_ptr <= rd_ptr + AW'(1);
         count         <= count_nx;
         rx_valid      <= (count_nx != '0);
         UART_CTS      <= (CW'(FIFO_DEPTH) - count) > CW'(CTS_MARGIN);
         rx_overrun    <= push_req_c & full_c;
         rx_frame_err  <= frame_err_c;
         rx_parity_err <= parity_err_c;
      end
   end

   // ------------------------------------------------------------------ TX
   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_t;

   tx_state_t            tx_state, tx_state_nx;
   logic [CNT_W-1:0]     tx_cnt;
   logic [IDX_W-1:0]     tx_idx, tx_idx_nx;
   logic [DATA_BITS-1:0] tx_buf;
   logic                 tx_par, tx_tick_c, accept_c, tx_line_c;

   assign tx_ready  = (tx_state == TX_IDLE) & rts_s & ~rst;
   assign accept_c  = tx_valid & tx_ready;
   assign tx_tick_c = (tx_cnt == '0);

   // TX state register
   always_ff @(posedge clk) begin
      if (rst) tx_state <= TX_IDLE;
      else     tx_state <= tx_state_nx;
   end

   // TX next-state logic, including the index of the next data bit
   always_comb begin
      tx_state_nx = tx_state;
      tx_idx_nx   = tx_idx;
      case (tx_state)
         TX_IDLE:   if (accept_c) tx_state_nx = TX_START;
         TX_START:  if (tx_tick_c) begin
                       tx_state_nx = TX_DATA;
                       tx_idx_nx   = '0;
                    end
         TX_DATA:   if (tx_tick_c) begin
                       tx_idx_nx = tx_idx + IDX_W'(1);
                       if (tx_idx == LAST_IDX) tx_state_nx = HAS_PAR ? TX_PARITY : TX_STOP;
                    end
         TX_PARITY: if (tx_tick_c) tx_state_nx = TX_STOP;
         TX_STOP:   if (tx_tick_c) tx_state_nx = TX_IDLE;
         default:   tx_state_nx = TX_IDLE;
      endcase
   end

   // TX line level for the upcoming state, so the registered line changes on the same edge as the state
   always_comb begin
      tx_line_c = 1'b1;
      case (tx_state_nx)
         TX_START:  tx_line_c = 1'b0;
         TX_DATA:   tx_line_c = tx_buf[tx_idx_nx];
         TX_PARITY: tx_line_c = tx_par;
         default:   tx_line_c = 1'b1;
      endcase
   end

   // TX datapath: latch the byte and its parity on accept, then time each bit
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_cnt  <= '0;
         tx_idx  <= '0;
         tx_buf  <= '0;
         tx_par  <= 1'b0;
         UART_Tx <= 1'b1;
      end else begin
         if (tx_state == TX_IDLE || tx_tick_c) tx_cnt <= BIT_RELOAD;
         else                                  tx_cnt <= tx_cnt - CNT_W'(1);
         if (accept_c) begin
            tx_buf <= tx_data;
            tx_par <= (^tx_data) ^ ODD_PAR;
         end
         tx_idx  <= tx_idx_nx;
         UART_Tx <= tx_line_c;
      end
   end

endmodule

// File: tb/tb_uart_flow_link.sv
// Directed bench for uart_flow_link. Instance a is 8N1 with a 4-deep FIFO and
// a margin of 1; instance b uses even parity with an 8-deep FIFO.
`timescale 1ns/1ps
module tb_uart_flow_link;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       a_rx, a_rts, a_tx, a_cts, a_rx_valid, a_rx_ready;
   logic       a_tx_valid, a_tx_ready, a_fe, a_pe, a_ov;
   logic [7:0] a_rx_data, a_tx_data;
   logic       b_rx, b_rts, b_tx, b_cts, b_rx_valid, b_rx_ready;
   logic       b_tx_valid, b_tx_ready, b_fe, b_pe, b_ov;
   logic [7:0] b_rx_data, b_tx_data;

   uart_flow_link #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(0),
                    .FIFO_DEPTH(4), .CTS_MARGIN(1)) dut_a (
      .clk(clk), .rst(rst), .UART_Rx(a_rx), .UART_RTS(a_rts),
      .UART_Tx(a_tx), .UART_CTS(a_cts),
      .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
      .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
      .rx_frame_err(a_fe), .rx_parity_err(a_pe), .rx_overrun(a_ov));

   uart_flow_link #(.CLKS_PER_BIT(8), .DATA_BITS(8), .PARITY(1),
                    .FIFO_DEPTH(8), .CTS_MARGIN(2)) dut_b (
      .clk(clk), .rst(rst), .UART_Rx(b_rx), .UART_RTS(b_rts),
      .UART_Tx(b_tx), .UART_CTS(b_cts),
      .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
      .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
      .rx_frame_err(b_fe), .rx_parity_err(b_pe), .rx_overrun(b_ov));

   int n_tests = 0;
   int n_fail  = 0;

   // Running pulse counts; the tests compare differences across a stimulus window
   int a_fe_n = 0, a_pe_n = 0, a_ov_n = 0, b_fe_n = 0, b_pe_n = 0, b_ov_n = 0;
   always @(posedge clk) begin
      if (a_fe === 1'b1) a_fe_n++;
      if (a_pe === 1'b1) a_pe_n++;
      if (a_ov === 1'b1) a_ov_n++;
      if (b_fe === 1'b1) b_fe_n++;
      if (b_pe === 1'b1) b_pe_n++;
      if (b_ov === 1'b1) b_ov_n++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance n clock edges, ending 1 ns after the last edge
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Serial bits are driven LSB first, 8 clocks per bit; sel 0 drives instance a and 1 drives instance b
   task automatic send(input int sel, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (sel == 0) a_rx = bits[i];
         else          b_rx = bits[i];
         step(8);
      end
   endtask

   task automatic pop_a();
      a_rx_ready = 1'b1;
      step(1);
      a_rx_ready = 1'b0;
   endtask

   // 8N1 frame: start, data, stop
   function automatic logic [15:0] f8n1(input logic [7:0] d);
      return {6'b0, 1'b1, d, 1'b0};
   endfunction

   // 8-bit frame with an explicit parity bit and stop bit
   function automatic logic [15:0] f8p(input logic [7:0] d, input logic par, input logic stop);
      return {5'b0, stop, par, d, 1'b0};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   logic [9:0] tx_exp;
   int         low, s0, s1, s2;

   initial begin
      rst = 1'b1;
      a_rx = 1'b1; a_rts = 1'b0; a_rx_ready = 1'b0; a_tx_data = 8'h00; a_tx_valid = 1'b0;
      b_rx = 1'b1; b_rts = 1'b0; b_rx_ready = 1'b0; b_tx_data = 8'h00; b_tx_valid = 1'b0;
      step(3);
      check("rst_tx", a_tx, 1);
      check("rst_cts", a_cts, 0);
      check("rst_rx_valid", a_rx_valid, 0);
      check("rst_tx_ready", a_tx_ready, 0);
      rst = 1'b0;
      step(1);
      check("cts_after_rst_a", a_cts, 1);
      check("cts_after_rst_b", b_cts, 1);
      a_rts = 1'b1;
      step(4);

      // RX 0xA5: rx_valid rises right after the stop-bit sample 80 clocks after the start edge
      s0 = a_fe_n; s1 = a_pe_n; s2 = a_ov_n;
      send(0, {7'b0, 8'hA5, 1'b0}, 9);
      a_rx = 1'b1;
      step(7);
      check("a5_valid_early", a_rx_valid, 0);
      step(1);
      check("a5_valid", a_rx_valid, 1);
      check("a5_data", a_rx_data, 8'hA5);
      step(3);
      check("a5_no_pulses", (a_fe_n - s0) + (a_pe_n - s1) + (a_ov_n - s2), 0);
      pop_a();
      check("a5_pop_empty", a_rx_valid, 0);

      // TX 0x3C: ten bits at 8 clocks each, tx_ready low for exactly 80 clocks
      tx_exp = {1'b1, 8'h3C, 1'b0};
      check("tx_ready_idle", a_tx_ready, 1);
      a_tx_data = 8'h3C;
      a_tx_valid = 1'b1;
      step(1);
      a_tx_valid = 1'b0;
      low = 0;
      for (int s = 0; s < 200; s++) begin
         if (a_tx_ready) break;
         low++;
         if (s % 8 == 4 && s / 8 < 10) check($sformatf("tx_bit%0d", s / 8), a_tx, tx_exp[s / 8]);
         step(1);
      end
      check("tx_busy_cycles", low, 80);
      check("tx_line_idle", a_tx, 1);

      // RTS low blocks the accept and the line stays idle
      a_rts = 1'b0;
      step(3);
      a_tx_data = 8'h99;
      a_tx_valid = 1'b1;
      step(20);
      check("rts0_line", a_tx, 1);
      check("rts0_ready", a_tx_ready, 0);
      a_tx_valid = 1'b0;
      a_rts = 1'b1;
      step(3);

      // FIFO fill on a with no pops: CTS drops after the 3rd push, the 5th byte overruns
      s2 = a_ov_n;
      send(0, f8n1(8'h01), 10); step(2);
      send(0, f8n1(8'h02), 10); step(2);
      check("cts_two_held", a_cts, 1);
      send(0, f8n1(8'h03), 10); step(2);
      check("cts_three_held", a_cts, 0);
      send(0, f8n1(8'h04), 10); step(2);
      send(0, f8n1(8'h05), 10); step(3);
      check("overrun_pulse", a_ov_n - s2, 1);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("fifo_valid%0d", k), a_rx_valid, 1);
         check($sformatf("fifo_data%0d", k), a_rx_data, 32'(k));
         pop_a();
      end
      check("fifo_drained", a_rx_valid, 0);
      step(2);
      check("cts_reopen", a_cts, 1);

      // Two-clock low glitch is rejected silently
      s0 = a_fe_n; s1 = a_pe_n; s2 = a_ov_n;
      a_rx = 1'b0;
      step(2);
      a_rx = 1'b1;
      step(40);
      check("glitch_no_push", a_rx_valid, 0);
      check("glitch_no_pulses", (a_fe_n - s0) + (a_pe_n - s1) + (a_ov_n - s2), 0);

      // Even parity on b: 0x07 needs parity 1, so sending 0 is a parity error
      s0 = b_fe_n; s1 = b_pe_n;
      send(1, f8p(8'h07, 1'b0, 1'b1), 11);
      step(3);
      check("par_err_pulse", b_pe_n - s1, 1);
      check("par_err_no_fe", b_fe_n - s0, 0);
      check("par_err_no_push", b_rx_valid, 0);

      // Stop bit low: frame error, then wait for the line to go high before the next frame
      s0 = b_fe_n; s1 = b_pe_n;
      send(1, f8p(8'h3A, 1'b0, 1'b0), 11);
      step(10);
      check("frame_err_pulse", b_fe_n - s0, 1);
      check("frame_err_no_pe", b_pe_n - s1, 0);
      check("frame_err_no_push", b_rx_valid, 0);
      b_rx = 1'b1;
      step(10);
      send(1, f8p(8'h3A, 1'b0, 1'b1), 11);
      step(2);
      check("recover_valid", b_rx_valid, 1);
      check("recover_data", b_rx_data, 8'h3A);
      check("recover_no_new_fe", b_fe_n - s0, 1);

      // Reset during TX bit 3 and an RX frame on a, with a byte already held in the FIFO
      send(0, f8n1(8'h11), 10);
      step(2);
      check("pre_rst_valid", a_rx_valid, 1);
      a_tx_data = 8'h3C;
      a_tx_valid = 1'b1;
      step(1);
      a_tx_valid = 1'b0;
      a_rx = 1'b0;
      step(8);
      a_rx = 1'b1;
      step(16);
      rst = 1'b1;
      step(1);
      check("mid_rst_tx", a_tx, 1);
      check("mid_rst_cts", a_cts, 0);
      check("mid_rst_valid", a_rx_valid, 0);
      check("mid_rst_ready", a_tx_ready, 0);
      rst = 1'b0;
      a_rx = 1'b1;
      step(1);
      check("post_rst_cts", a_cts, 1);
      step(4);
      check("post_rst_tx_idle", a_tx, 1);
      check("post_rst_ready", a_tx_ready, 1);
      send(0, f8n1(8'h55), 10);
      step(2);
      check("post_rst_valid", a_rx_valid, 1);
      check("post_rst_data", a_rx_data, 8'h55);
      pop_a();
      check("post_rst_single", a_rx_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
